mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal values: even, 8..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits, selecting the operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands (a = multiplicand/dividend, b = multiplier/divisor).
REQ-007 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that the result is valid.
REQ-009 The block SHALL have ports hi and lo, output, WIDTH bits each: the result registers.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: the last completed divide had b = 0.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and FIX only.
REQ-012 In IDLE with start=1 at an edge, the block SHALL latch op, the magnitudes of a/b (signed ops) or raw a/b (unsigned ops) and both sign bits, clear the iteration counter, and enter CALC.
REQ-013 CALC SHALL iterate exactly WIDTH edges: shift-add for multiply, restoring shift-subtract for divide, one bit per edge.
REQ-014 FIX SHALL last one edge: it applies sign correction, writes hi/lo and div_by_zero, asserts done for the following cycle, and returns to IDLE.
REQ-015 Latency SHALL be fixed: done high in the cycle after the (WIDTH+1)th edge following the accepting edge, for every op and operand value.
REQ-016 busy SHALL be 1 from the accepting edge until the FIX edge, and 0 while done is 1.
REQ-017 start while busy=1 SHALL be ignored; start in the done cycle SHALL be accepted.
REQ-018 a, b and op changes after the accepting edge SHALL NOT affect the result.
REQ-019 MULTU/MULT SHALL produce {hi,lo} = the full 2*WIDTH-bit unsigned/signed product.
REQ-020 DIVU/DIV SHALL produce lo = quotient truncated toward zero and hi = remainder, with the remainder taking the sign of the dividend.
REQ-021 For a divide with b=0, the block SHALL produce lo = all ones and hi = a with unchanged latency, and div_by_zero = 1; any multiply or nonzero-divisor divide SHALL clear div_by_zero.
REQ-022 DIV of the most-negative value by -1 SHALL give lo = the most-negative value and hi = 0, with no flag.
REQ-023 hi, lo and div_by_zero SHALL hold their values from one FIX edge to the next.

Reset
REQ-024 When rst_n=0, the block SHALL immediately force state IDLE, busy 0, done 0, hi 0, lo 0, div_by_zero 0, and clear the counter and datapath registers.
REQ-025 Reset during CALC or FIX SHALL abort the operation, produce no done pulse, and leave the block accepting start on the first edge after release.

Structure
REQ-026 The op encodings and FSM state encodings SHALL live in the shared header mdu_defs.vh, included by the RTL and the bench.
REQ-027 The block SHALL contain one sub-module, mdu_addsub: a WIDTH-bit combinational adder/subtractor with carry out, shared by multiply and divide.
REQ-028 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification (WIDTH=32)
REQ-029 Bench SHALL apply MULTU a=0xFFFFFFFF b=0xFFFFFFFF and check hi=0xFFFFFFFE, lo=0x00000001, with done exactly 33 cycles after the accepting edge.
REQ-030 Bench SHALL apply MULT a=-3 b=5 and check hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-031 Bench SHALL apply DIV a=-7 b=2 and check lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0.
REQ-032 Bench SHALL apply DIVU a=100 b=0 and check lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1; a following MULTU 2*3 SHALL give lo=6 with div_by_zero=0.
REQ-033 Bench SHALL start MULTU 7*9, pulse start with DIVU 10/3 at cycle 5 (ignored), and check one done with lo=63; DIVU 10/3 issued in the done cycle SHALL then give lo=3, hi=1.
REQ-034 Bench SHALL drop rst_n at cycle 10 of a MULT and check busy, done, hi and lo go to 0 immediately, no done pulse occurs, and a restarted MULT 4*4 gives lo=16.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Typed views of the shared op and state encodings for the multiply/divide unit.
package mult_div_unit_pkg;
`include "mdu_defs.vh"

   typedef enum logic [1:0] {
      ST_IDLE = `MDU_ST_IDLE,
      ST_CALC = `MDU_ST_CALC,
      ST_FIX  = `MDU_ST_FIX
   } state_t;

   localparam logic [1:0] OP_MULTU = `MDU_OP_MULTU;
   localparam logic [1:0] OP_MULT  = `MDU_OP_MULT;
   localparam logic [1:0] OP_DIVU  = `MDU_OP_DIVU;
   localparam logic [1:0] OP_DIV   = `MDU_OP_DIV;

endpackage

// File: rtl/mdu_addsub.sv
// Combinational WIDTH-bit adder/subtractor; for subtraction cout=1 means no borrow.
module mdu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] b_eff;

   always_comb begin
      b_eff       = sub ? ~b : b;
      {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
   end

endmodule

// File: rtl/mdu_defs.vh
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
`ifndef MDU_DEFS_VH
`define MDU_DEFS_VH

`define MDU_OP_MULTU 2'b00
`define MDU_OP_MULT  2'b01
`define MDU_OP_DIVU  2'b10
`define MDU_OP_DIV   2'b11

`define MDU_ST_IDLE  2'b00
`define MDU_ST_CALC  2'b01
`define MDU_ST_FIX   2'b10

`endif

// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit: one bit per cycle on operand magnitudes,
// sign correction applied in a single FIX cycle, fixed WIDTH+1 cycle latency.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state, state_nxt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] acc, qreg, mag_b;
   logic             sign_a, sign_b, b_zero;
   logic [CW-1:0]    cnt;

   logic             accept, calc_en, fix_en, last;
   logic             is_div, is_signed, div_ok;
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_cout;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix, fix_hi, fix_lo;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start) state_nxt = ST_CALC;
         ST_CALC: if (last)  state_nxt = ST_FIX;
         ST_FIX:             state_nxt = ST_IDLE;
         default:            state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy    = (state != ST_IDLE);
      accept  = (state == ST_IDLE) && start;
      calc_en = (state == ST_CALC);
      fix_en  = (state == ST_FIX);
      last    = (cnt == CW'(WIDTH - 1));
   end

   assign is_div    = op_q[1];
   assign is_signed = op_q[0];

   // Multiply adds b into the high half when the next multiplier bit is set;
   // divide trial-subtracts b from the remainder shifted left by one bit.
   always_comb begin
      if (is_div) begin
         add_a = {acc[WIDTH-2:0], qreg[WIDTH-1]};
         add_b = mag_b;
      end else begin
         add_a = acc;
         add_b = qreg[0] ? mag_b : '0;
      end
   end

   mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a    (add_a),
      .b    (add_b),
      .sub  (is_div),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // The bit shifted out of acc is the 33rd bit of the trial remainder.
   assign div_ok = acc[WIDTH-1] | add_cout;

   always_comb begin
      prod     = {acc, qreg};
      prod_fix = (is_signed && (sign_a ^ sign_b)) ? -prod : prod;
      quo_fix  = (is_signed && (sign_a ^ sign_b)) ? -qreg : qreg;
      rem_fix  = (is_signed && sign_a) ? -acc : acc;
      if (is_div) begin
         fix_hi = rem_fix;
         fix_lo = b_zero ? '1 : quo_fix;
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   // Datapath: acc holds the product high half / remainder, qreg the
   // multiplier being consumed / quotient being built.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         acc    <= '0;
         qreg   <= '0;
         mag_b  <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         op_q   <= op;
         sign_a <= a[WIDTH-1];
         sign_b <= b[WIDTH-1];
         qreg   <= (op[0] && a[WIDTH-1]) ? -a : a;
         mag_b  <= (op[0] && b[WIDTH-1]) ? -b : b;
         b_zero <= (b == '0);
         acc    <= '0;
         cnt    <= '0;
      end else if (calc_en) begin
         cnt <= cnt + CW'(1);
         if (is_div) begin
            acc  <= div_ok ? add_sum : add_a;
            qreg <= {qreg[WIDTH-2:0], div_ok};
         end else begin
            acc  <= {add_cout, add_sum[WIDTH-1:1]};
            qreg <= {add_sum[0], qreg[WIDTH-1:1]};
         end
      end
   end

   // Result registers change only on the FIX edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= fix_en;
         if (fix_en) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            div_by_zero <= is_div && b_zero;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int W = 32;

   logic         clk, rst_n, start;
   logic [1:0]   op;
   logic [W-1:0] a, b, hi, lo;
   logic         busy, done, div_by_zero;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   logic [2*W:0] exp_q[$];  // {div_by_zero, hi, lo}
   int           lat_q[$];  // cycle number of each accepting edge

   mult_div_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   // Clock and cycle count
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Drive one request starting now (between edges); returns #1 after the edge.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edbz);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom_range(0, 3));
      a     = $urandom;
      b     = $urandom;
      if (push) begin
         exp_q.push_back({edbz, ehi, elo});
         lat_q.push_back(cyc);
      end
   endtask

   // Returns at the falling edge where done is seen, or flags a timeout.
   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         fails++;
         $display("FAIL %s: done not seen within 100 cycles", name);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
         end else begin
            logic [2*W:0] e;
            int           acc_cyc;
            e       = exp_q.pop_front();
            acc_cyc = lat_q.pop_front();
            check("hi", 64'(hi), 64'(e[2*W-1:W]));
            check("lo", 64'(lo), 64'(e[W-1:0]));
            check("div_by_zero", 64'(div_by_zero), 64'(e[2*W]));
            check("latency", 64'(cyc - acc_cyc), 64'(W + 1));
            check("busy_in_done", 64'(busy), 64'd0);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      check("busy_after_accept", 64'(busy), 64'd1);
      wait_done("multu_max");
      issue(OP_MULT, -32'sd3, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      wait_done("mult_neg");
      issue(OP_DIV, -32'sd7, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      wait_done("div_neg");
      issue(OP_DIVU, 32'd100, 32'd0, 1, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
      wait_done("divu_zero");
      issue(OP_MULTU, 32'd2, 32'd3, 1, 32'h0, 32'd6, 1'b0);
      wait_done("multu_small");
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 1'b0);
      wait_done("div_min_m1");
      issue(OP_DIV, 32'd7, -32'sd2, 1, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      wait_done("div_neg_divisor");
      issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0, 1'b0);
      wait_done("mult_min_min");
      issue(OP_DIV, -32'sd5, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
      wait_done("div_zero_signed");
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1, 32'h0, 32'hFFFF_FFFF, 1'b0);
      wait_done("divu_by_one");

      // Start while busy is ignored; start in the done cycle is accepted.
      @(negedge clk);
      issue(OP_MULTU, 32'd7, 32'd9, 1, 32'h0, 32'd63, 1'b0);
      repeat (4) @(negedge clk);
      issue(OP_DIVU, 32'd10, 32'd3, 0, '0, '0, 1'b0);
      wait_done("multu_7x9");
      issue(OP_DIVU, 32'd10, 32'd3, 1, 32'd1, 32'd3, 1'b0);
      wait_done("divu_10_3");

      // Reset mid-operation aborts without a done pulse.
      @(negedge clk);
      issue(OP_MULT, -32'sd3, 32'd5, 0, '0, '0, 1'b0);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(OP_MULT, 32'd4, 32'd4, 1, 32'h0, 32'd16, 1'b0);
      wait_done("mult_after_reset");

      repeat (40) @(negedge clk);
      check("pending_ops", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
